// File: rtl/usb_sd_xfer_ctrl.sv
// Multi-block USB/SD transfer sequencer: IN (SD read -> USB transmit) and OUT (USB receive -> SD write),
// with a per-wait timeout, bounded per-block retry and a sticky abort flag.
module usb_sd_xfer_ctrl #(
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLK_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [3:0]           rx_pid,
  input  logic                 pid_rdy,
  input  logic [1:0]           rx_packet_done,
  input  logic [BLK_CNT_W-1:0] blk_count,
  input  logic                 sd_done,
  input  logic                 sd_err,
  input  logic                 tx_done,
  input  logic                 tx_err,
  output logic                 sd_addr_rdy,
  output logic                 sd_read,
  output logic                 sd_write,
  output logic                 tx_send_good,
  output logic                 tx_send_bad,
  output logic                 tx_transmit,
  output logic                 busy,
  output logic                 xfer_err,
  output logic [BLK_CNT_W-1:0] blocks_done
);

  localparam logic [3:0] PID_OUT = 4'b0001;
  localparam logic [3:0] PID_IN  = 4'b1001;
  localparam logic [3:0] PID_ACK = 4'b0010;
  localparam logic [3:0] PID_NAK = 4'b1010;

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, ADDR, WR_DATA, WR_SD, WR_HS, RD_SD, RD_TX, RD_HS, ERR
  } state_e;

  state_e               state_q, state_d;
  logic                 dir_in_q, dir_in_d;
  logic [BLK_CNT_W-1:0] count_q, count_d;
  logic [BLK_CNT_W-1:0] blocks_q, blocks_d;
  logic [RTY_W-1:0]     retry_q, retry_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 xfer_err_q, xfer_err_d;
  logic                 addr_q, addr_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 good_q, good_d;
  logic                 bad_q, bad_d;
  logic                 xmit_q, xmit_d;

  logic timeout, retry_ok, last_blk, pid_ack, pid_nak, is_wait, tmr_restart;

  assign timeout  = (tmr_q == TMR_LAST);
  assign retry_ok = (retry_q < RTY_MAX);
  assign last_blk = ((blocks_q + BLK_CNT_W'(1)) == count_q);
  assign pid_ack  = pid_rdy && (rx_pid == PID_ACK);
  assign pid_nak  = pid_rdy && (rx_pid == PID_NAK);
  assign is_wait  = state_q inside {WR_DATA, WR_SD, WR_HS, RD_SD, RD_TX, RD_HS};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      dir_in_q   <= 1'b0;
      count_q    <= '0;
      blocks_q   <= '0;
      retry_q    <= '0;
      tmr_q      <= '0;
      xfer_err_q <= 1'b0;
      addr_q     <= 1'b0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      xmit_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_in_q   <= dir_in_d;
      count_q    <= count_d;
      blocks_q   <= blocks_d;
      retry_q    <= retry_d;
      tmr_q      <= tmr_d;
      xfer_err_q <= xfer_err_d;
      addr_q     <= addr_d;
      read_q     <= read_d;
      write_q    <= write_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      xmit_q     <= xmit_d;
    end
  end

  // Strobes are decided on the transition so that each registered pulse lasts exactly one cycle.
  always_comb begin
    state_d     = state_q;
    dir_in_d    = dir_in_q;
    count_d     = count_q;
    blocks_d    = blocks_q;
    retry_d     = retry_q;
    xfer_err_d  = xfer_err_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    xmit_d      = 1'b0;
    tmr_restart = 1'b0;

    case (state_q)
      IDLE: begin
        if (pid_rdy && (rx_pid == PID_OUT || rx_pid == PID_IN)) begin
          dir_in_d   = (rx_pid == PID_IN);
          count_d    = (blk_count == '0) ? BLK_CNT_W'(1) : blk_count;
          blocks_d   = '0;
          retry_d    = '0;
          xfer_err_d = 1'b0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (dir_in_q) begin
          read_d  = 1'b1;
          state_d = RD_SD;
        end else begin
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_packet_done == 2'b01) begin
          write_d = 1'b1;
          state_d = WR_SD;
        end else if (rx_packet_done == 2'b10 || timeout) begin
          if (retry_ok) begin
            retry_d     = retry_q + RTY_W'(1);
            bad_d       = 1'b1;
            tmr_restart = 1'b1;
          end else begin
            state_d = ERR;
          end
        end
      end
      WR_SD: begin
        if (sd_err) begin
          bad_d   = 1'b1;
          state_d = ERR;
        end else if (sd_done) begin
          good_d  = 1'b1;
          state_d = WR_HS;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      WR_HS: begin
        if (tx_err || (!tx_done && timeout)) begin
          if (retry_ok) begin
            retry_d     = retry_q + RTY_W'(1);
            good_d      = 1'b1;
            tmr_restart = 1'b1;
          end else begin
            state_d = ERR;
          end
        end else if (tx_done) begin
          blocks_d = blocks_q + BLK_CNT_W'(1);
          retry_d  = '0;
          state_d  = last_blk ? IDLE : ADDR;
        end
      end
      RD_SD: begin
        if (sd_err) begin
          state_d = ERR;
        end else if (sd_done) begin
          xmit_d  = 1'b1;
          state_d = RD_TX;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      RD_TX: begin
        if (tx_err || (!tx_done && timeout)) begin
          if (retry_ok) begin
            retry_d     = retry_q + RTY_W'(1);
            xmit_d      = 1'b1;
            tmr_restart = 1'b1;
          end else begin
            state_d = ERR;
          end
        end else if (tx_done) begin
          state_d = RD_HS;
        end
      end
      RD_HS: begin
        if (pid_ack) begin
          blocks_d = blocks_q + BLK_CNT_W'(1);
          retry_d  = '0;
          state_d  = last_blk ? IDLE : ADDR;
        end else if (pid_nak || timeout) begin
          if (retry_ok) begin
            retry_d = retry_q + RTY_W'(1);
            xmit_d  = 1'b1;
            state_d = RD_TX;
          end else begin
            state_d = ERR;
          end
        end
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    addr_d = (state_d == ADDR);
    if (state_d == ERR) xfer_err_d = 1'b1;

    if (!is_wait || tmr_restart || state_d != state_q) tmr_d = '0;
    else tmr_d = tmr_q + TMR_W'(1);
  end

  assign sd_addr_rdy  = addr_q;
  assign sd_read      = read_q;
  assign sd_write     = write_q;
  assign tx_send_good = good_q;
  assign tx_send_bad  = bad_q;
  assign tx_transmit  = xmit_q;
  assign busy         = (state_q != IDLE);
  assign xfer_err     = xfer_err_q;
  assign blocks_done  = blocks_q;

endmodule
